// File: rtl/axi_hndshk_join_if.sv
// Handshake bundle for the N-lane join: per-lane source valid/ready/data on
// one side and a single aligned destination beat on the other.
interface axi_hndshk_join_if #(
  parameter int N_INPUTS = 2,
  parameter int DATA_W   = 8
);
  logic [N_INPUTS-1:0]        valid_src;
  logic [N_INPUTS-1:0]        ready_src;
  logic [N_INPUTS*DATA_W-1:0] data_src;
  logic                       valid_dst;
  logic                       ready_dst;
  logic [N_INPUTS*DATA_W-1:0] data_dst;

  // master: the environment feeding the lanes and consuming the joined beat
  modport master (
    output valid_src, data_src, ready_dst,
    input  ready_src, valid_dst, data_dst
  );

  // slave: the join block itself
  modport slave (
    input  valid_src, data_src, ready_dst,
    output ready_src, valid_dst, data_dst
  );
endinterface

// File: rtl/axi_hndshk_join.sv
// Joins N valid/ready source lanes into one registered destination beat.
// Each lane has a one-entry holding register so lanes may arrive skewed.
module axi_hndshk_join #(
  parameter int N_INPUTS = 2,
  parameter int DATA_W   = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi_hndshk_join_if.slave bus
);
  localparam int BUS_W = N_INPUTS * DATA_W;

  logic [N_INPUTS-1:0] full_reg;
  logic [N_INPUTS-1:0] full_next;
  logic [N_INPUTS-1:0] accept;
  logic [N_INPUTS-1:0] ready_src;
  logic [DATA_W-1:0]   hold_reg [N_INPUTS];
  logic [BUS_W-1:0]    joined;
  logic                out_v_reg;
  logic                out_v_next;
  logic [BUS_W-1:0]    out_d_reg;
  logic [BUS_W-1:0]    out_d_next;
  logic                drain;
  logic                fire;

  // The output stage can take a beat when empty or being consumed this cycle.
  assign drain = ~out_v_reg | bus.ready_dst;
  assign fire  = (&full_reg) & drain;

  // Lane ready comes only from registered state and ready_dst, never valid_src,
  // so a full lane reopens in the same cycle its beat moves to the output.
  genvar gi;
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : g_lane
      assign ready_src[gi]                   = ~full_reg[gi] | fire;
      assign accept[gi]                      = bus.valid_src[gi] & ready_src[gi];
      assign joined[gi*DATA_W +: DATA_W]     = hold_reg[gi];
    end
  endgenerate

  always_comb begin
    full_next  = (full_reg & ~{N_INPUTS{fire}}) | accept;
    out_v_next = out_v_reg;
    out_d_next = out_d_reg;
    if (fire) begin
      out_v_next = 1'b1;
      out_d_next = joined;
    end else if (bus.ready_dst) begin
      out_v_next = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full_reg  <= '0;
      out_v_reg <= 1'b0;
      out_d_reg <= '0;
      for (int i = 0; i < N_INPUTS; i++) hold_reg[i] <= '0;
    end else begin
      full_reg  <= full_next;
      out_v_reg <= out_v_next;
      out_d_reg <= out_d_next;
      for (int i = 0; i < N_INPUTS; i++) begin
        if (accept[i]) hold_reg[i] <= bus.data_src[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.ready_src = ready_src;
  assign bus.valid_dst = out_v_reg;
  assign bus.data_dst  = out_d_reg;
endmodule
